// File: rtl/dma_pkg.sv
// Shared definitions for the 8237A-style DMA register file: port map, command bits, mode layout.
package dma_pkg;

    localparam logic [3:0] PORT_CMD     = 4'h8;
    localparam logic [3:0] PORT_STATUS  = 4'h8;
    localparam logic [3:0] PORT_REQ     = 4'h9;
    localparam logic [3:0] PORT_SGLMASK = 4'hA;
    localparam logic [3:0] PORT_MODE    = 4'hB;
    localparam logic [3:0] PORT_CLRFF   = 4'hC;
    localparam logic [3:0] PORT_MCLR    = 4'hD;
    localparam logic [3:0] PORT_TEMP    = 4'hD;
    localparam logic [3:0] PORT_CLRMASK = 4'hE;
    localparam logic [3:0] PORT_WRMASK  = 4'hF;

    localparam int CMD_ADDR_HOLD = 1;

    // Mode register image is the written byte without its channel-select bits.
    typedef struct packed {
        logic [1:0] mode;
        logic       dec;
        logic       autoinit;
        logic [1:0] xfer;
    } mode_t;

endpackage

// File: rtl/dma_ch_counter.sv
// One DMA channel's base/current address and word-count registers with byte loading,
// transfer stepping, autoinit reload and terminal-count detection.
module dma_ch_counter #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wrAddr,
    input  logic          wrWord,
    input  logic          hiByte,
    input  logic [7:0]    data,
    input  logic          step,
    input  logic          dec,
    input  logic          holdAddr,
    input  logic          autoinit,
    output logic [AW-1:0] curAddr,
    output logic [AW-1:0] curWord,
    output logic          tc
);

    localparam int HW = AW - 8;

    logic [AW-1:0] baseAddr;
    logic [AW-1:0] baseWord;
    logic          doStep;

    // A CPU load of this channel suppresses the step entirely, so no TC can fire either.
    assign doStep = step && !wrAddr && !wrWord && !clr;
    assign tc     = doStep && (curWord == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baseAddr <= '0;
            baseWord <= '0;
            curAddr  <= '0;
            curWord  <= '0;
        end else if (clr) begin
            baseAddr <= '0;
            baseWord <= '0;
            curAddr  <= '0;
            curWord  <= '0;
        end else if (wrAddr) begin
            if (hiByte) begin
                baseAddr[AW-1:8] <= HW'(data);
                curAddr[AW-1:8]  <= HW'(data);
            end else begin
                baseAddr[7:0] <= data;
                curAddr[7:0]  <= data;
            end
        end else if (wrWord) begin
            if (hiByte) begin
                baseWord[AW-1:8] <= HW'(data);
                curWord[AW-1:8]  <= HW'(data);
            end else begin
                baseWord[7:0] <= data;
                curWord[7:0]  <= data;
            end
        end else if (doStep) begin
            if (tc && autoinit) begin
                curAddr <= baseAddr;
                curWord <= baseWord;
            end else begin
                curWord <= curWord - AW'(1);
                if (!holdAddr)
                    curAddr <= dec ? curAddr - AW'(1) : curAddr + AW'(1);
            end
        end
    end

endmodule

// File: rtl/dma_reg_file.sv
// CPU-programmable register file of the 8237A-style DMA: I/O decode, byte-pointer FF,
// shared control/status registers and one address/word counter per channel.
module dma_reg_file
    import dma_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int AW     = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                CS_N,
    input  logic                IOR_N,
    input  logic                IOW_N,
    input  logic [3:0]          ioAddr,
    input  logic [7:0]          dataIn,
    output logic [7:0]          dataOut,
    output logic                dataOe,
    input  logic [3:0]          dreq,
    input  logic                xferStep,
    input  logic [1:0]          activeCh,
    output logic [AW-1:0]       outAddr,
    output logic                tcPulse,
    output logic [7:0]          commandReg,
    output logic [NUM_CH*6-1:0] modeReg,
    output logic [3:0]          requestReg,
    output logic [3:0]          maskReg,
    output logic [7:0]          statusReg
);

    logic              iowPrev;
    logic              iorPrev;
    logic              ff;
    logic [3:0]        stTc;
    logic [7:0]        tempReg;
    mode_t             modeQ [NUM_CH];
    logic [AW-1:0]     curAddr [NUM_CH];
    logic [AW-1:0]     curWord [NUM_CH];
    logic [NUM_CH-1:0] tcVec;
    logic              wrEv;
    logic              rdEnd;
    logic              isChPort;
    logic              mclr;
    logic              stepValid;
    logic              tcEv;
    logic [AW-1:0]     rdSel;

    assign wrEv      = !CS_N && !IOW_N && iowPrev;
    assign rdEnd     = !CS_N && IOR_N && !iorPrev;
    assign isChPort  = !ioAddr[3];
    assign mclr      = wrEv && (ioAddr == PORT_MCLR);
    assign stepValid = xferStep && (int'(activeCh) < NUM_CH);
    assign tcEv      = |tcVec;
    assign dataOe    = !CS_N && !IOR_N;
    assign statusReg = {dreq, stTc};
    assign outAddr   = (int'(activeCh) < NUM_CH) ? curAddr[activeCh] : '0;

    for (genvar n = 0; n < NUM_CH; n++) begin : gCh
        dma_ch_counter #(.AW(AW)) uCnt (
            .clk      (CLK),
            .rst      (RESET),
            .clr      (mclr),
            .wrAddr   (wrEv && isChPort && int'(ioAddr[2:1]) == n && !ioAddr[0]),
            .wrWord   (wrEv && isChPort && int'(ioAddr[2:1]) == n && ioAddr[0]),
            .hiByte   (ff),
            .data     (dataIn),
            .step     (stepValid && int'(activeCh) == n),
            .dec      (modeQ[n].dec),
            .holdAddr ((n == 0) && commandReg[CMD_ADDR_HOLD]),
            .autoinit (modeQ[n].autoinit),
            .curAddr  (curAddr[n]),
            .curWord  (curWord[n]),
            .tc       (tcVec[n])
        );
        assign modeReg[n*6 +: 6] = modeQ[n];
    end

    always_comb begin
        dataOut = '0;
        rdSel   = '0;
        if (dataOe) begin
            if (isChPort) begin
                if (int'(ioAddr[2:1]) < NUM_CH) begin
                    rdSel   = ioAddr[0] ? curWord[ioAddr[2:1]] : curAddr[ioAddr[2:1]];
                    dataOut = ff ? 8'(rdSel >> 8) : rdSel[7:0];
                end
            end else if (ioAddr == PORT_STATUS) begin
                dataOut = statusReg;
            end else if (ioAddr == PORT_TEMP) begin
                dataOut = tempReg;
            end
        end
    end

    // Later assignments in this block deliberately override earlier ones: TC effects beat CPU writes
    // and status clears, master clear beats everything.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            iowPrev    <= 1'b1;
            iorPrev    <= 1'b1;
            ff         <= 1'b0;
            stTc       <= '0;
            tempReg    <= '0;
            tcPulse    <= 1'b0;
            commandReg <= '0;
            requestReg <= '0;
            maskReg    <= '1;
            for (int unsigned i = 0; i < NUM_CH; i++) modeQ[i] <= '0;
        end else begin
            iowPrev <= IOW_N;
            iorPrev <= IOR_N;
            if (mclr) begin
                ff         <= 1'b0;
                stTc       <= '0;
                tempReg    <= '0;
                tcPulse    <= 1'b0;
                commandReg <= '0;
                requestReg <= '0;
                maskReg    <= '1;
                for (int unsigned i = 0; i < NUM_CH; i++) modeQ[i] <= '0;
            end else begin
                tcPulse <= tcEv;
                if ((wrEv || rdEnd) && isChPort)
                    ff <= !ff;
                if (rdEnd && ioAddr == PORT_STATUS)
                    stTc <= '0;
                if (wrEv) begin
                    case (ioAddr)
                        PORT_CMD:     commandReg <= dataIn;
                        PORT_REQ:     if (int'(dataIn[1:0]) < NUM_CH) requestReg[dataIn[1:0]] <= dataIn[2];
                        PORT_SGLMASK: if (int'(dataIn[1:0]) < NUM_CH) maskReg[dataIn[1:0]] <= dataIn[2];
                        PORT_MODE:    if (int'(dataIn[1:0]) < NUM_CH) modeQ[dataIn[1:0]] <= mode_t'(dataIn[7:2]);
                        PORT_CLRFF:   ff <= 1'b0;
                        PORT_CLRMASK: maskReg <= '0;
                        PORT_WRMASK:  maskReg <= dataIn[3:0];
                        default:      ;
                    endcase
                end
                if (tcEv) begin
                    stTc[activeCh]       <= 1'b1;
                    requestReg[activeCh] <= 1'b0;
                    if (!modeQ[activeCh].autoinit)
                        maskReg[activeCh] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_reg_file.sv
// Directed bench for dma_reg_file: expected values are queued as stimulus is applied and
// compared when the DUT produces the corresponding output.
module tb_dma_reg_file;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CS_N;
    logic        IOR_N;
    logic        IOW_N;
    logic [3:0]  ioAddr;
    logic [7:0]  dataIn;
    logic [7:0]  dataOut;
    logic        dataOe;
    logic [3:0]  dreq;
    logic        xferStep;
    logic [1:0]  activeCh;
    logic [15:0] outAddr;
    logic        tcPulse;
    logic [7:0]  commandReg;
    logic [23:0] modeReg;
    logic [3:0]  requestReg;
    logic [3:0]  maskReg;
    logic [7:0]  statusReg;

    int nCompared = 0;
    int nMismatch = 0;

    string       tagQ[$];
    logic [31:0] expQ[$];

    dma_reg_file #(.NUM_CH(4), .AW(16)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .CS_N       (CS_N),
        .IOR_N      (IOR_N),
        .IOW_N      (IOW_N),
        .ioAddr     (ioAddr),
        .dataIn     (dataIn),
        .dataOut    (dataOut),
        .dataOe     (dataOe),
        .dreq       (dreq),
        .xferStep   (xferStep),
        .activeCh   (activeCh),
        .outAddr    (outAddr),
        .tcPulse    (tcPulse),
        .commandReg (commandReg),
        .modeReg    (modeReg),
        .requestReg (requestReg),
        .maskReg    (maskReg),
        .statusReg  (statusReg)
    );

    always #5 CLK = ~CLK;

    task automatic push(input string tag, input logic [31:0] exp);
        tagQ.push_back(tag);
        expQ.push_back(exp);
    endtask

    task automatic pop(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        nCompared++;
        if (expQ.size() == 0) begin
            nMismatch++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            t = tagQ.pop_front();
            e = expQ.pop_front();
            assert (obs === e) else begin
                nMismatch++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] exp, input logic [31:0] obs);
        push(tag, exp);
        pop(obs);
    endtask

    task automatic cpuWr(input logic [3:0] a, input logic [7:0] d);
        @(negedge CLK);
        CS_N = 1'b0; IOW_N = 1'b0; ioAddr = a; dataIn = d;
        @(negedge CLK);
        CS_N = 1'b1; IOW_N = 1'b1;
    endtask

    task automatic cpuRd(input string tag, input logic [3:0] a, input logic [7:0] exp);
        push(tag, 32'(exp));
        @(negedge CLK);
        CS_N = 1'b0; IOR_N = 1'b0; ioAddr = a;
        #1 pop(32'(dataOut));
        @(negedge CLK);
        IOR_N = 1'b1;
        @(negedge CLK);
        CS_N = 1'b1;
    endtask

    task automatic xfer(input logic [1:0] ch);
        @(negedge CLK);
        xferStep = 1'b1; activeCh = ch;
        @(negedge CLK);
        xferStep = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1; CS_N = 1'b1; IOR_N = 1'b1; IOW_N = 1'b1;
        ioAddr = '0; dataIn = '0; dreq = '0; xferStep = 1'b0; activeCh = '0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_mask",    32'h0F, 32'(maskReg));
        chk("rst_cmd",     32'h00, 32'(commandReg));
        chk("rst_mode",    32'h0,  32'(modeReg));
        chk("rst_req",     32'h0,  32'(requestReg));
        chk("rst_status",  32'h00, 32'(statusReg));
        chk("rst_tc",      32'h0,  32'(tcPulse));
        chk("rst_outAddr", 32'h0,  32'(outAddr));
        chk("rst_dataOut", 32'h0,  32'(dataOut));
        chk("rst_dataOe",  32'h0,  32'(dataOe));

        dreq = 4'hA;

        // ch1 address through the byte pointer
        cpuWr(4'hC, 8'h00);
        cpuWr(4'h2, 8'h34);
        cpuWr(4'h2, 8'h12);
        activeCh = 2'd1;
        #1 chk("ch1_addr", 32'h1234, 32'(outAddr));
        cpuRd("rd_ch1_lo", 4'h2, 8'h34);
        cpuRd("rd_ch1_hi", 4'h2, 8'h12);
        cpuRd("rd_ch1_ff0", 4'h2, 8'h34);
        cpuWr(4'hC, 8'h00);

        // ch0 non-autoinit terminal count
        cpuWr(4'hE, 8'h00);
        chk("mask_clr", 32'h0, 32'(maskReg));
        cpuWr(4'hB, 8'h00);
        cpuWr(4'hC, 8'h00);
        cpuWr(4'h0, 8'h00);
        cpuWr(4'h0, 8'h20);
        cpuWr(4'h1, 8'h01);
        cpuWr(4'h1, 8'h00);
        xfer(2'd0);
        chk("ch0_step1_tc",   32'h0,    32'(tcPulse));
        chk("ch0_step1_addr", 32'h2001, 32'(outAddr));
        cpuRd("ch0_word0_lo", 4'h1, 8'h00);
        cpuRd("ch0_word0_hi", 4'h1, 8'h00);
        xfer(2'd0);
        chk("ch0_tc_pulse",  32'h1,    32'(tcPulse));
        @(negedge CLK);
        chk("ch0_tc_once",   32'h0,    32'(tcPulse));
        chk("ch0_status",    32'hA1,   32'(statusReg));
        chk("ch0_mask",      32'h1,    32'(maskReg));
        chk("ch0_step2_addr",32'h2002, 32'(outAddr));
        cpuRd("ch0_wordF_lo", 4'h1, 8'hFF);
        cpuRd("ch0_wordF_hi", 4'h1, 8'hFF);
        cpuRd("status_rd", 4'h8, 8'hA1);
        chk("status_clr", 32'hA0, 32'(statusReg));

        // ch3 autoinit, decrementing
        cpuWr(4'h9, 8'h07);
        chk("req_set", 32'h8, 32'(requestReg));
        cpuWr(4'hB, 8'h33);
        chk("mode_ch3", 32'h300000, 32'(modeReg));
        cpuWr(4'hC, 8'h00);
        cpuWr(4'h6, 8'h00);
        cpuWr(4'h6, 8'h10);
        cpuWr(4'h7, 8'h00);
        cpuWr(4'h7, 8'h00);
        xfer(2'd3);
        chk("ch3_tc",     32'h1,    32'(tcPulse));
        chk("ch3_reload", 32'h1000, 32'(outAddr));
        chk("ch3_status", 32'hA8,   32'(statusReg));
        chk("ch3_mask",   32'h1,    32'(maskReg));
        chk("ch3_req",    32'h0,    32'(requestReg));
        cpuRd("ch3_word_lo", 4'h7, 8'h00);
        cpuRd("ch3_word_hi", 4'h7, 8'h00);

        // ch0 address hold
        cpuWr(4'h8, 8'h02);
        chk("cmd", 32'h02, 32'(commandReg));
        xfer(2'd0);
        chk("hold_tc",   32'h0,    32'(tcPulse));
        chk("hold_addr", 32'h2002, 32'(outAddr));
        cpuRd("hold_word_lo", 4'h1, 8'hFE);
        cpuRd("hold_word_hi", 4'h1, 8'hFF);

        // CPU word write colliding with a ch0 step on a zero count
        cpuWr(4'hC, 8'h00);
        cpuWr(4'h1, 8'h00);
        cpuWr(4'h1, 8'h00);
        @(negedge CLK);
        CS_N = 1'b0; IOW_N = 1'b0; ioAddr = 4'h1; dataIn = 8'h55;
        xferStep = 1'b1; activeCh = 2'd0;
        @(negedge CLK);
        CS_N = 1'b1; IOW_N = 1'b1; xferStep = 1'b0;
        chk("coll_tc",     32'h0,  32'(tcPulse));
        chk("coll_status", 32'hA8, 32'(statusReg));
        cpuWr(4'hC, 8'h00);
        cpuRd("coll_word_lo", 4'h1, 8'h55);
        cpuRd("coll_word_hi", 4'h1, 8'h00);

        cpuRd("rd_unmapped", 4'hA, 8'h00);
        chk("idle_dataOut", 32'h0, 32'(dataOut));
        chk("idle_dataOe",  32'h0, 32'(dataOe));

        // master clear
        cpuWr(4'hD, 8'h00);
        chk("mclr_mask",    32'hF,  32'(maskReg));
        chk("mclr_cmd",     32'h0,  32'(commandReg));
        chk("mclr_status",  32'hA0, 32'(statusReg));
        chk("mclr_outAddr", 32'h0,  32'(outAddr));
        chk("mclr_mode",    32'h0,  32'(modeReg));
        chk("mclr_req",     32'h0,  32'(requestReg));

        // async reset in the middle of a transfer
        cpuWr(4'hE, 8'h00);
        cpuWr(4'h8, 8'h02);
        cpuWr(4'h0, 8'h78);
        chk("pre_rst_addr", 32'h0078, 32'(outAddr));
        @(negedge CLK);
        xferStep = 1'b1; activeCh = 2'd0;
        #2 RESET = 1'b1;
        #1;
        chk("arst_mask",    32'hF,  32'(maskReg));
        chk("arst_cmd",     32'h0,  32'(commandReg));
        chk("arst_outAddr", 32'h0,  32'(outAddr));
        chk("arst_tc",      32'h0,  32'(tcPulse));
        chk("arst_status",  32'hA0, 32'(statusReg));
        @(negedge CLK);
        xferStep = 1'b0;
        RESET = 1'b0;
        @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
